list_execute_sm: RTL and testbench
==================================

// Module: list_execute_sm
// PURPOSE
//  802.1Q-2018 8.6.9.2 List Execute state machine; consumes the CycleStart pulse of the cycle timer.
//  On each CycleStart, walks the gate control list (GCL) from entry 0.
//  Drives each entry's gate states for that entry's TimeInterval; the last entry's states hold until the next cycle.
//  Sits between cycle timer and per-port transmission selection; GCL lives in an external sync-read RAM.
// PARAMETERS
//  NUM_QUEUES     8   gate vector width, one bit per traffic class (1 = open)
//  ADDR_W         4   GCL address width; list holds up to 2**ADDR_W entries
//  TI_WIDTH       32  TimeInterval width, ns
//  CLK_PERIOD_NS  8   clk period in ns; must be a power of two (division is a shift)
// PORTS
//  clk                 in   1            system clock
//  rst                 in   1            synchronous reset, active-high
//  gate_enable         in   1            0: block idle, all gates open
//  CycleStart          in   1            1-cycle pulse from cycle timer
//  oper_list_len       in   ADDR_W+1     number of valid GCL entries (0..2**ADDR_W)
//  list_addr           out  ADDR_W       GCL read address
//  list_gate_states    in   NUM_QUEUES   GCL data, valid 1 cycle after list_addr
//  list_time_interval  in   TI_WIDTH     GCL data, valid 1 cycle after list_addr
//  oper_gate_states    out  NUM_QUEUES   current gate states
//  list_pointer        out  ADDR_W+1     index of next entry to fetch
//  cycle_done          out  1            1-cycle pulse when last entry's interval expires
//  cycle_overrun       out  1            1-cycle pulse when CycleStart truncates an unfinished list
// BEHAVIOUR
//  Clock and reset: single clk domain; reset is synchronous, active-high (rst sampled on posedge clk only).
//  Reset values: state=IDLE, oper_gate_states=all 1s, list_pointer=0, cycle_done=0, cycle_overrun=0, cnt=0, latched len=0.
//  list_addr = list_pointer[ADDR_W-1:0], combinational.
//  States:
//   IDLE: gates all 1s. If gate_enable & CycleStart -> FETCH, with pointer=0 and len_q=oper_list_len.
//   FETCH: address presented. If len_q==0 -> END. Else -> APPLY.
//   APPLY: gate_states <= list_gate_states; pointer++; cnt <= sat0(ceil(T/CLK_PERIOD_NS)-3). -> DELAY.
//   DELAY: if cnt==0 -> FETCH when pointer<len_q. Else -> END with cycle_done pulse. If cnt!=0, cnt--.
//   END: hold gates; wait for CycleStart.
//  Priority: rst > ~gate_enable (-> IDLE, gates all 1s next cycle) > CycleStart > normal flow.
//  CycleStart in FETCH/APPLY/DELAY: restart as from IDLE (pointer=0, len_q relatched, -> FETCH) and pulse cycle_overrun.
//  CycleStart in END: restart with no overrun pulse.
//  oper_list_len is sampled only at CycleStart; later changes take effect next cycle.
//  Latency: CycleStart high in cycle 0 -> FETCH in cycle 1 -> APPLY in cycle 2 -> entry 0 gates visible from cycle 3.
//  Hold time, non-last entry: exactly N = max(ceil(T/CLK_PERIOD_NS), 3) cycles.
//   FETCH and APPLY of the next entry overlap the current hold. T < 3*CLK_PERIOD_NS is stretched to 3 cycles.
//  Hold time, last entry: held until next CycleStart (or ~gate_enable).
//   cycle_done pulses in the cycle where DELAY exits to END.
//  Arithmetic: ceil via (T + P-1) >> log2(P), in TI_WIDTH+1 bits (no overflow at T=max).
//   Subtraction of 3 saturates at 0. cnt is TI_WIDTH bits.
//  len_q > 2**ADDR_W is clamped to 2**ADDR_W. Pointer never wraps within a cycle.
//  Gate vector 0 (all closed) and all-ones are legal entry values; no masking.
// TESTING
//  1. Reset mid-DELAY -> next cycle: IDLE, oper_gate_states=8'hFF, list_pointer=0, no pulses.
//  2. len=2, E0={8'h01,80ns}, E1={8'h02,40ns}; CycleStart @c0.
//     -> 8'h01 on c3..c12 (10 cycles); 8'h02 from c13; cycle_done @c16; 8'h02 held until next CycleStart.
//  3. Entry T=0 and T=20ns (P=8) -> each held exactly 3 cycles.
//  4. len=3 of 1000ns entries; second CycleStart 50 cycles after the first
//     -> cycle_overrun pulse that cycle; entry 0 gates again 3 cycles later; pointer restarts at 0.
//  5. len=0 -> FETCH then END; gates stay all 1s after reset; no cycle_done; next CycleStart no overrun.
//  6. gate_enable deasserted mid-list -> next cycle gates 8'hFF, IDLE; CycleStart ignored while low.
//     Reassert + CycleStart -> list restarts at entry 0.

Source files
------------

// File: rtl/list_execute_sm.sv
// Gate control list executor: on each CycleStart, walks the GCL from entry 0 and
// drives each entry's gate states for its TimeInterval; the last entry holds until the next cycle.
module list_execute_sm #(
  parameter int NUM_QUEUES    = 8,
  parameter int ADDR_W        = 4,
  parameter int TI_WIDTH      = 32,
  parameter int CLK_PERIOD_NS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gate_enable,
  input  logic                  CycleStart,
  input  logic [ADDR_W:0]       oper_list_len,
  output logic [ADDR_W-1:0]     list_addr,
  input  logic [NUM_QUEUES-1:0] list_gate_states,
  input  logic [TI_WIDTH-1:0]   list_time_interval,
  output logic [NUM_QUEUES-1:0] oper_gate_states,
  output logic [ADDR_W:0]       list_pointer,
  output logic                  cycle_done,
  output logic                  cycle_overrun
);

  localparam int SHIFT = $clog2(CLK_PERIOD_NS);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_DELAY,
    S_END
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     len_q;
  logic [TI_WIDTH-1:0] cnt;
  logic [TI_WIDTH:0]   ti_ceil;
  logic [TI_WIDTH-1:0] cnt_load;
  logic [ADDR_W:0]     len_clamped;
  logic                list_busy;

  assign list_addr = list_pointer[ADDR_W-1:0];

  // FETCH and APPLY of the next entry overlap the current hold, so the delay
  // counter is loaded three cycles short of the full interval (never below zero).
  assign ti_ceil  = ({1'b0, list_time_interval} + (TI_WIDTH+1)'(CLK_PERIOD_NS - 1)) >> SHIFT;
  assign cnt_load = (ti_ceil > (TI_WIDTH+1)'(3)) ? TI_WIDTH'(ti_ceil - (TI_WIDTH+1)'(3)) : '0;

  assign len_clamped = (oper_list_len > MAX_LEN) ? MAX_LEN : oper_list_len;
  assign list_busy   = (state == S_FETCH) || (state == S_APPLY) || (state == S_DELAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      oper_gate_states <= '1;
      list_pointer     <= '0;
      cycle_done       <= 1'b0;
      cycle_overrun    <= 1'b0;
      cnt              <= '0;
      len_q            <= '0;
    end else if (!gate_enable) begin
      state            <= S_IDLE;
      oper_gate_states <= '1;
      list_pointer     <= '0;
      cycle_done       <= 1'b0;
      cycle_overrun    <= 1'b0;
      cnt              <= '0;
    end else if (CycleStart) begin
      state         <= S_FETCH;
      list_pointer  <= '0;
      len_q         <= len_clamped;
      cycle_done    <= 1'b0;
      cycle_overrun <= list_busy;
    end else begin
      cycle_done    <= 1'b0;
      cycle_overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          oper_gate_states <= '1;
        end
        S_FETCH: begin
          if (len_q == '0) state <= S_END;
          else             state <= S_APPLY;
        end
        S_APPLY: begin
          oper_gate_states <= list_gate_states;
          list_pointer     <= list_pointer + 1'b1;
          cnt              <= cnt_load;
          state            <= S_DELAY;
        end
        S_DELAY: begin
          if (cnt == '0) begin
            if (list_pointer < len_q) begin
              state <= S_FETCH;
            end else begin
              state      <= S_END;
              cycle_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_END: begin
          state <= S_END;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_list_execute_sm.sv
// Bench for list_execute_sm: a GCL RAM model plus a schedule-level reference that
// derives per-cycle gates/pointer/pulses from entry start times and hold lengths.
module tb_list_execute_sm;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate_enable;
  logic        CycleStart;
  logic [4:0]  oper_list_len;
  logic [3:0]  list_addr;
  logic [7:0]  list_gate_states;
  logic [31:0] list_time_interval;
  logic [7:0]  oper_gate_states;
  logic [4:0]  list_pointer;
  logic        cycle_done;
  logic        cycle_overrun;

  logic [7:0]  gcl_gs [16];
  logic [31:0] gcl_ti [16];

  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] prev_g;
  bit   prev_busy;

  always #4 clk = ~clk;

  // external synchronous-read GCL memory
  always_ff @(posedge clk) begin
    list_gate_states   <= gcl_gs[list_addr];
    list_time_interval <= gcl_ti[list_addr];
  end

  list_execute_sm #(
    .NUM_QUEUES(8), .ADDR_W(4), .TI_WIDTH(32), .CLK_PERIOD_NS(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gate_enable(gate_enable),
    .CycleStart(CycleStart),
    .oper_list_len(oper_list_len),
    .list_addr(list_addr),
    .list_gate_states(list_gate_states),
    .list_time_interval(list_time_interval),
    .oper_gate_states(oper_gate_states),
    .list_pointer(list_pointer),
    .cycle_done(cycle_done),
    .cycle_overrun(cycle_overrun)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx, input logic [7:0] g, input int p, input bit d, input bit o);
    logic [4:0] pp;
    pp = 5'(p);
    check_output({ctx, " gates"},    32'(oper_gate_states), 32'(g));
    check_output({ctx, " pointer"},  32'(list_pointer),     32'(pp));
    check_output({ctx, " addr"},     32'(list_addr),        32'(pp[3:0]));
    check_output({ctx, " done"},     32'(cycle_done),       32'(d));
    check_output({ctx, " overrun"},  32'(cycle_overrun),    32'(o));
  endtask

  // Starts a list cycle at the current negedge and checks ncyc following cycles.
  task automatic apply_stimulus(input string ctx, input int len, input int ncyc, input bit change_len);
    int st [17];
    int dur [16];
    int len_eff, done_t, busy_t, p, ti;
    bit exp_ovr;
    logic [7:0] g;
    len_eff = (len > 16) ? 16 : len;
    st[0] = 3;
    for (int i = 0; i < len_eff; i++) begin
      ti = int'(gcl_ti[i]);
      dur[i] = (ti + P - 1) / P;
      if (dur[i] < 3) dur[i] = 3;
      st[i+1] = st[i] + dur[i];
    end
    done_t  = (len_eff > 0) ? st[len_eff-1] + dur[len_eff-1] - 2 : -1;
    busy_t  = (len_eff > 0) ? done_t : 2;
    exp_ovr = prev_busy;
    g = prev_g;
    CycleStart    = 1'b1;
    oper_list_len = 5'(len);
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      CycleStart = 1'b0;
      if (change_len && t == 4) oper_list_len = 5'($urandom_range(0, 31));
      p = 0;
      for (int i = 0; i < len_eff; i++) if (st[i] <= t) p++;
      g = (p == 0) ? prev_g : gcl_gs[p-1];
      check_all(ctx, g, p, (t == done_t), (t == 1) && exp_ovr);
    end
    prev_g    = g;
    prev_busy = (ncyc < busy_t);
  endtask

  initial begin
    rst = 1'b1;
    gate_enable = 1'b1;
    CycleStart = 1'b0;
    oper_list_len = '0;
    for (int i = 0; i < 16; i++) begin
      gcl_gs[i] = '0;
      gcl_ti[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_all("reset", 8'hFF, 0, 1'b0, 1'b0);
    rst = 1'b0;
    prev_g = 8'hFF;
    prev_busy = 1'b0;
    @(negedge clk);
    check_all("idle", 8'hFF, 0, 1'b0, 1'b0);

    // two-entry list with exact hold and done timing
    gcl_gs[0] = 8'h01; gcl_ti[0] = 80;
    gcl_gs[1] = 8'h02; gcl_ti[1] = 40;
    apply_stimulus("two_entry", 2, 22, 1'b1);
    apply_stimulus("two_entry_again", 2, 20, 1'b0);

    // short intervals stretched to three cycles, and 24/25ns boundary
    gcl_gs[0] = 8'hA5; gcl_ti[0] = 0;
    gcl_gs[1] = 8'h00; gcl_ti[1] = 20;
    gcl_gs[2] = 8'hFF; gcl_ti[2] = 24;
    gcl_gs[3] = 8'h3C; gcl_ti[3] = 25;
    apply_stimulus("short_ti", 4, 25, 1'b0);

    // overrun: restart after 50 cycles of a long list
    gcl_gs[0] = 8'h11; gcl_ti[0] = 1000;
    gcl_gs[1] = 8'h22; gcl_ti[1] = 1000;
    gcl_gs[2] = 8'h33; gcl_ti[2] = 1000;
    apply_stimulus("long_list", 3, 50, 1'b0);
    apply_stimulus("overrun", 3, 10, 1'b0);

    // synchronous reset while in DELAY
    rst = 1'b1;
    @(negedge clk);
    check_all("reset_mid", 8'hFF, 0, 1'b0, 1'b0);
    rst = 1'b0;
    prev_g = 8'hFF;
    prev_busy = 1'b0;

    // empty list
    apply_stimulus("empty", 0, 5, 1'b0);
    apply_stimulus("empty_again", 0, 4, 1'b0);

    // length clamp to 16 entries
    for (int i = 0; i < 16; i++) begin
      gcl_gs[i] = 8'(i * 17 + 1);
      gcl_ti[i] = 0;
    end
    apply_stimulus("clamp", 20, 60, 1'b1);

    // gate_enable dropped mid-list, CycleStart ignored while low
    gcl_ti[0] = 1000; gcl_ti[1] = 1000;
    apply_stimulus("pre_disable", 2, 20, 1'b0);
    gate_enable = 1'b0;
    @(negedge clk);
    check_all("disable", 8'hFF, 0, 1'b0, 1'b0);
    CycleStart = 1'b1;
    oper_list_len = 5'd2;
    @(negedge clk);
    CycleStart = 1'b0;
    check_all("disable_cs", 8'hFF, 0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_all("disable_hold", 8'hFF, 0, 1'b0, 1'b0);
    end
    gate_enable = 1'b1;
    prev_g = 8'hFF;
    prev_busy = 1'b0;
    apply_stimulus("reenable", 2, 20, 1'b0);

    // randomized lists, some truncated by the next CycleStart
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 16; i++) begin
        gcl_gs[i] = 8'($urandom);
        gcl_ti[i] = $urandom_range(0, 400);
      end
      apply_stimulus("random", int'($urandom_range(0, 20)), int'($urandom_range(2, 150)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
